// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: load-use hazard detection with multi-cycle bubbles, memory freeze,
// branch-flush priority and a saturating bubble counter.
module hazard_unit_mc #(
    parameter int REG_ADDR_W      = 5,
    parameter int NUM_SRC         = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          MemRead_EX_i,
    input  logic [REG_ADDR_W-1:0]         RDaddr_EX_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] RSaddr_ID_i,
    input  logic [NUM_SRC-1:0]            RSUse_ID_i,
    input  logic                          MemStall_i,
    input  logic                          BranchTaken_ID_i,
    output logic                          Stall_o,
    output logic                          PCWrite_o,
    output logic                          NoOP_o,
    output logic                          Flush_o,
    output logic [CNT_W-1:0]              BubbleCnt_o
);
    localparam int CW = LOAD_USE_CYCLES > 1 ? $clog2(LOAD_USE_CYCLES) : 1;

    typedef enum logic {IDLE, LU_STALL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          hit;

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            if (RSUse_ID_i[k] && RSaddr_ID_i[k*REG_ADDR_W +: REG_ADDR_W] == RDaddr_EX_i)
                hit = 1'b1;
        hit = hit && MemRead_EX_i && (RDaddr_EX_i != '0);
    end

    // Reset forces the pass-through outputs so the pipeline is never held while in reset.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        Stall_o   = 1'b0;
        PCWrite_o = 1'b1;
        NoOP_o    = 1'b0;
        Flush_o   = 1'b0;
        if (!rst_i) begin
            state_n = IDLE;
        end else if (MemStall_i) begin
            Stall_o   = 1'b1;
            PCWrite_o = 1'b0;
        end else if (state == LU_STALL || hit) begin
            Stall_o   = 1'b1;
            PCWrite_o = 1'b0;
            NoOP_o    = 1'b1;
            if (state == LU_STALL) begin
                cnt_n   = cnt - CW'(1);
                state_n = (cnt == CW'(1)) ? IDLE : LU_STALL;
            end else if (LOAD_USE_CYCLES > 1) begin
                cnt_n   = CW'(LOAD_USE_CYCLES - 1);
                state_n = LU_STALL;
            end
        end else begin
            Flush_o = BranchTaken_ID_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            BubbleCnt_o <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (NoOP_o && !(&BubbleCnt_o))
                BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: scoreboard bench driving three configurations (1 bubble, 3 bubbles,
// 2-bit saturating counter) from shared directed vectors.
module tb_hazard_unit_mc;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       mem_read = 1'b0;
    logic [4:0] rd = '0;
    logic [9:0] rs = '0;
    logic [1:0] use_v = '0;
    logic       mem_stall = 1'b0;
    logic       br = 1'b0;

    logic        st1, pc1, no1, fl1, st3, pc3, no3, fl3, sts, pcs, nos, fls;
    logic [31:0] cnt1, cnt3;
    logic [1:0]  cnts;

    typedef struct {
        logic [3:0] e1;
        logic [3:0] e3;
        int         c1;
        int         c3;
        int         cs;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    localparam logic [3:0] D = 4'b0100, B = 4'b1010, F = 4'b1000, L = 4'b0101;

    always #5 clk = ~clk;

    hazard_unit_mc #(.LOAD_USE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd),
        .RSaddr_ID_i(rs), .RSUse_ID_i(use_v), .MemStall_i(mem_stall), .BranchTaken_ID_i(br),
        .Stall_o(st1), .PCWrite_o(pc1), .NoOP_o(no1), .Flush_o(fl1), .BubbleCnt_o(cnt1));

    hazard_unit_mc #(.LOAD_USE_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd),
        .RSaddr_ID_i(rs), .RSUse_ID_i(use_v), .MemStall_i(mem_stall), .BranchTaken_ID_i(br),
        .Stall_o(st3), .PCWrite_o(pc3), .NoOP_o(no3), .Flush_o(fl3), .BubbleCnt_o(cnt3));

    hazard_unit_mc #(.LOAD_USE_CYCLES(1), .CNT_W(2)) duts (
        .clk_i(clk), .rst_i(rst_i), .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd),
        .RSaddr_ID_i(rs), .RSUse_ID_i(use_v), .MemStall_i(mem_stall), .BranchTaken_ID_i(br),
        .Stall_o(sts), .PCWrite_o(pcs), .NoOP_o(nos), .Flush_o(fls), .BubbleCnt_o(cnts));

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Stimulus: applied 1 time unit after a rising edge; expected values queued alongside.
    int step_no = 0;
    task automatic step(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s0, input logic [1:0] u, input logic ms, input logic b,
                        input logic [3:0] e1, input logic [3:0] e3, input int c1, input int c3,
                        input int cs);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = r; mem_read = m_r(mr); rd = d; rs = {s1, s0}; use_v = u; mem_stall = ms; br = b;
        e.e1 = e1; e.e3 = e3; e.c1 = c1; e.c3 = c3; e.cs = cs; e.idx = step_no;
        q.push_back(e);
        step_no++;
    endtask

    function automatic logic m_r(input logic x);
        return x;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("outs_lu1", e.idx, int'({st1, pc1, no1, fl1}), int'(e.e1));
                chk("outs_lu3", e.idx, int'({st3, pc3, no3, fl3}), int'(e.e3));
                chk("cnt_lu1", e.idx, int'(cnt1), e.c1);
                chk("cnt_lu3", e.idx, int'(cnt3), e.c3);
                chk("cnt_sat", e.idx, int'(cnts), e.cs);
                chk("outs_sat", e.idx, int'({sts, pcs, nos, fls}), int'(e.e1));
            end
        end
    end

    initial begin : driver
        //    rst mr rd  rs1 rs0 use ms br  e1 e3 c1 c3 cs
        step(0, 1, 5, 0, 5, 2'b01, 0, 0, D, D, 0, 0, 0);   // reset overrides a hit
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 0, 0, 0);
        step(1, 1, 5, 0, 5, 2'b01, 0, 0, B, B, 0, 0, 0);   // basic load-use
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 1, 1, 1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 1, 2, 1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 1, 3, 1);
        step(1, 1, 0, 0, 0, 2'b01, 0, 0, D, D, 1, 3, 1);   // x0 ignored
        step(1, 1, 7, 7, 3, 2'b01, 0, 0, D, D, 1, 3, 1);   // rs2 match but unused
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, L, L, 1, 3, 1);   // branch, no hit
        step(1, 1, 9, 9, 0, 2'b10, 0, 1, B, B, 1, 3, 1);   // branch with hit
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, L, B, 2, 4, 2);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 2, 5, 2);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 2, 6, 2);
        step(1, 1, 9, 9, 0, 2'b10, 0, 0, B, B, 2, 6, 2);   // freeze inside stall
        step(1, 0, 0, 0, 0, 2'b00, 1, 0, F, F, 3, 7, 3);
        step(1, 0, 0, 0, 0, 2'b00, 1, 0, F, F, 3, 7, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 3, 7, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 3, 8, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 3, 9, 3);
        step(1, 1, 5, 0, 5, 2'b01, 1, 0, F, F, 3, 9, 3);   // hit under freeze not registered
        step(1, 1, 5, 0, 5, 2'b01, 0, 0, B, B, 3, 9, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 4, 10, 3);
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 0, 0, 0);   // reset mid-stall
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 0, 0, 0);
        step(1, 1, 3, 3, 3, 2'b11, 0, 0, B, B, 0, 0, 0);   // repeated hazards, saturation
        step(1, 1, 3, 3, 3, 2'b11, 0, 0, B, B, 1, 1, 1);
        step(1, 1, 3, 3, 3, 2'b11, 0, 0, B, B, 2, 2, 2);
        step(1, 1, 3, 3, 3, 2'b11, 0, 0, B, B, 3, 3, 3);
        step(1, 1, 3, 3, 3, 2'b11, 0, 0, B, B, 4, 4, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, B, 5, 5, 3);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, D, D, 5, 6, 3);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation load-use hazard unit for the 5-stage RISC-V pipeline. Sits beside the ID stage and drives the PC write enable, the IF/ID hold, ID/EX bubble injection and the IF/ID flush.
- Adds a configurable number of load-use bubbles for deeper data-memory paths, and a configurable number of source operands with per-operand use qualifiers.
- Ignores x0, supports a whole-pipeline freeze on data-memory stalls, resolves priority against taken-branch flushes, and counts injected bubbles.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, number of ID-stage source operands checked (1..3).
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..4).
- CNT_W, 32, width of the bubble performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- MemRead_EX_i  in  1  instruction in EX is a load.
- RDaddr_EX_i  in  REG_ADDR_W  destination register of the EX instruction.
- RSaddr_ID_i  in  NUM_SRC*REG_ADDR_W  packed ID source addresses; operand k at bits [k*REG_ADDR_W +: REG_ADDR_W].
- RSUse_ID_i  in  NUM_SRC  bit k=1 means the ID instruction actually reads operand k.
- MemStall_i  in  1  data memory not ready; whole pipeline must freeze.
- BranchTaken_ID_i  in  1  branch or jump resolved taken in ID.
- Stall_o  out  1  hold IF/ID.
- PCWrite_o  out  1  PC write enable.
- NoOP_o  out  1  inject a bubble into ID/EX.
- Flush_o  out  1  flush IF/ID.
- BubbleCnt_o  out  CNT_W  saturating count of injected bubbles.

Behaviour:
- Hit, combinational: MemRead_EX_i && RDaddr_EX_i!=0 && for some k, RSUse_ID_i[k] && RSaddr_ID_i[k]==RDaddr_EX_i.
- States: IDLE and LU_STALL. Registered down-counter cnt is wide enough for LOAD_USE_CYCLES-1.
- Output priority (highest first):
  - (1) MemStall_i → Stall_o=1, PCWrite_o=0, NoOP_o=0, Flush_o=0. State and cnt hold; counter does not advance. A hit coincident with MemStall_i is not registered; it is re-evaluated once the freeze ends, because the EX contents are unchanged.
  - (2) state==LU_STALL, or IDLE with a hit → Stall_o=1, PCWrite_o=0, NoOP_o=1, Flush_o=0. BranchTaken_ID_i is ignored because ID operands are stale.
  - (3) Otherwise → Stall_o=0, PCWrite_o=1, NoOP_o=0, Flush_o=BranchTaken_ID_i.
- Transitions:
  - IDLE, with a hit and no MemStall_i: if LOAD_USE_CYCLES>1, go to LU_STALL with cnt=LOAD_USE_CYCLES-1. Otherwise stay in IDLE; the single bubble is this cycle.
  - LU_STALL, no MemStall_i: cnt decrements. When cnt==1 in the current cycle, the next state is IDLE. The EX inputs are not re-examined while in LU_STALL, since EX holds a bubble.
- Total bubbles per hazard is exactly LOAD_USE_CYCLES, excluding freeze cycles.
- After returning to IDLE, the stalled ID instruction proceeds. No re-detection occurs because EX now holds a bubble with MemRead=0.
- BubbleCnt_o increments by 1 on every edge where NoOP_o=1. It saturates at all-ones and does not wrap.
- Reset (rst_i=0, asynchronous): state=IDLE, cnt=0, BubbleCnt_o=0.
  - While reset is asserted, outputs are forced to Stall_o=0, PCWrite_o=1, NoOP_o=0, Flush_o=0, regardless of the other inputs.
  - Reset during LU_STALL abandons the stall immediately.
- All outputs except BubbleCnt_o are combinational from the inputs and state, giving same-cycle response. BubbleCnt_o is registered.

Test Plan:
- **Basic load-use:** LOAD_USE_CYCLES=1; EX: MemRead=1, rd=5; ID: rs1=5, use=1 → one cycle of Stall_o=1, PCWrite_o=0, NoOP_o=1; next cycle (EX bubble) all default; BubbleCnt_o=1.
- **x0 and use qualifiers:** EX load rd=0 with rs1=0 → no stall. EX load rd=7 with rs2=7 and RSUse[1]=0 → no stall.
- **Multi-bubble:** LOAD_USE_CYCLES=3, load rd=9, ID rs2=9 → exactly 3 consecutive NoOP_o cycles, then IDLE; BubbleCnt_o=3.
- **Freeze inside stall:** LOAD_USE_CYCLES=3, MemStall_i high for 2 cycles in the 2nd bubble → those 2 cycles show Stall_o=1, NoOP_o=0; NoOP_o totals 3; overall stall spans 5 cycles.
- **Branch priority:** BranchTaken_ID_i=1 with a hit → Flush_o=0 and stall asserted. BranchTaken_ID_i=1 with no hit → Flush_o=1, PCWrite_o=1.
- **Reset and saturation:**
  - rst_i low mid-LU_STALL → outputs go to defaults immediately and BubbleCnt_o=0; after release, the state is IDLE.
  - CNT_W=2 with 5 hazards → BubbleCnt_o holds at 3.
